// File: rtl/countdown_control_pkg.sv
// Shared types and defaults for the countdown control front end.
// State encoding is visible on the STATE output, so it is fixed here.
package countdown_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } state_e;

    localparam int LP_DEBOUNCE_CYCLES   = 1000000;
    localparam int LP_DEBOUNCE_WIDTH    = 20;
    localparam int LP_BLINK_HALF_PERIOD = 50000000;
    localparam int LP_BLINK_WIDTH       = 26;

endpackage

// File: rtl/countdown_control_if.sv
// Button, counter-chain and indicator signals of the countdown control.
// master drives buttons and COUNT_IS_ZERO; slave is the controller.
interface countdown_control_if;

    logic       BTN_START;
    logic       BTN_CLEAR;
    logic       COUNT_IS_ZERO;
    logic       ENABLE;
    logic       COUNTER_RESET;
    logic [1:0] STATE;
    logic       ALARM_LED;

    modport master (
        output BTN_START,
        output BTN_CLEAR,
        output COUNT_IS_ZERO,
        input  ENABLE,
        input  COUNTER_RESET,
        input  STATE,
        input  ALARM_LED
    );

    modport slave (
        input  BTN_START,
        input  BTN_CLEAR,
        input  COUNT_IS_ZERO,
        output ENABLE,
        output COUNTER_RESET,
        output STATE,
        output ALARM_LED
    );

endinterface

// File: rtl/countdown_control_button_debounce.sv
// Raw push-button conditioner: 2-flop sync, stability counter and
// a one-cycle pulse on the accepted press edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DEBOUNCE_WIDTH  = 20
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN_IN,
    output logic LEVEL,
    output logic PRESS_PULSE
);

    localparam logic [DEBOUNCE_WIDTH-1:0] LP_LAST =
        DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                      r_sync1;
    logic                      r_sync2;
    logic                      r_stable;
    logic                      r_stable_d;
    logic [DEBOUNCE_WIDTH-1:0] r_cnt;

    // Any return to the stable level restarts the count, so glitches
    // shorter than DEBOUNCE_CYCLES never reach r_stable.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= BTN_IN;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + DEBOUNCE_WIDTH'(1);
            end
        end
    end

    assign LEVEL       = r_stable;
    assign PRESS_PULSE = r_stable & ~r_stable_d;

endmodule

// File: rtl/countdown_control.sv
// Stopwatch-style controller for the 4-digit down-counter chain:
// debounced start/pause and clear, zero stop, and expiry alarm blink.
module countdown_control
    import countdown_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = LP_DEBOUNCE_CYCLES,
    parameter int DEBOUNCE_WIDTH    = LP_DEBOUNCE_WIDTH,
    parameter int BLINK_HALF_PERIOD = LP_BLINK_HALF_PERIOD,
    parameter int BLINK_WIDTH       = LP_BLINK_WIDTH
) (
    input  logic                CLK,
    input  logic                RESET,
    countdown_control_if.slave  bus
);

    localparam logic [BLINK_WIDTH-1:0] LP_BLINK_LAST =
        BLINK_WIDTH'(BLINK_HALF_PERIOD - 1);

    state_e                 r_state;
    state_e                 w_next;
    logic                   r_ctr_rst;
    logic [BLINK_WIDTH-1:0] r_blink_cnt;
    logic                   r_phase;
    logic                   w_start_p;
    logic                   w_clear_p;
    logic                   w_unused_start_lvl;
    logic                   w_unused_clear_lvl;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEBOUNCE_WIDTH  (DEBOUNCE_WIDTH)
    ) u_db_start (
        .CLK         (CLK),
        .RESET       (RESET),
        .BTN_IN      (bus.BTN_START),
        .LEVEL       (w_unused_start_lvl),
        .PRESS_PULSE (w_start_p)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEBOUNCE_WIDTH  (DEBOUNCE_WIDTH)
    ) u_db_clear (
        .CLK         (CLK),
        .RESET       (RESET),
        .BTN_IN      (bus.BTN_CLEAR),
        .LEVEL       (w_unused_clear_lvl),
        .PRESS_PULSE (w_clear_p)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_ctr_rst <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ctr_rst <= w_clear_p;
        end
    end

    // Clear wins everywhere; reaching zero wins over a pause press.
    always_comb begin
        w_next = r_state;
        if (w_clear_p) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_p) w_next = ST_RUNNING;
                end
                ST_RUNNING: begin
                    if (bus.COUNT_IS_ZERO) w_next = ST_EXPIRED;
                    else if (w_start_p)    w_next = ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (w_start_p) w_next = ST_RUNNING;
                end
                ST_EXPIRED: begin
                    w_next = ST_EXPIRED;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || (r_state != ST_EXPIRED)) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == LP_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_WIDTH'(1);
        end
    end

    assign bus.ENABLE        = (r_state == ST_RUNNING) & ~bus.COUNT_IS_ZERO;
    assign bus.COUNTER_RESET = r_ctr_rst;
    assign bus.STATE         = r_state;
    assign bus.ALARM_LED     = (r_state == ST_EXPIRED) & r_phase;

endmodule
